// File: rtl/word_to_byte_lane.sv
// rtl/word_to_byte_lane.sv - 32-bit lane word to MSB-first byte stream with 2-entry word FIFO
module word_to_byte_lane #(
    parameter logic [7:0] IDLE_SYM = 8'hBC
) (
    input  logic        clk_4f,
    input  logic        reset_L,
    input  logic [31:0] data_in,
    input  logic        valid_in,
    output logic        in_ready,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        err_overflow
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic [1:0]  byte_idx;
    logic [1:0]  byte_idx_next;
    logic [31:0] head_word;
    logic [31:0] tail_word;
    logic        push;
    logic        pop;
    logic        drop;
    logic [7:0]  head_byte;
    logic [7:0]  data_out_next;
    logic        valid_out_next;

    // The FIFO accepts only when it has a free slot; a pop in the same cycle does not open one.
    assign in_ready = (count < 2'd2);
    assign push     = valid_in && in_ready;
    assign drop     = valid_in && !in_ready;
    assign pop      = (state == SEND) && (byte_idx == 2'd3);

    // Select the current byte of the head word, most significant first.
    always_comb begin
        head_byte = head_word[31:24];
        case (byte_idx)
            2'd0: head_byte = head_word[31:24];
            2'd1: head_byte = head_word[23:16];
            2'd2: head_byte = head_word[15:8];
            2'd3: head_byte = head_word[7:0];
            default: head_byte = head_word[31:24];
        endcase
    end

    // Occupancy after this edge's push and pop.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Next-state, byte index and registered-output values for the control FSM.
    always_comb begin
        state_next     = state;
        byte_idx_next  = byte_idx;
        data_out_next  = IDLE_SYM;
        valid_out_next = 1'b0;
        case (state)
            IDLE: begin
                byte_idx_next = 2'd0;
                if ((count != 2'd0) || push) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                data_out_next  = head_byte;
                valid_out_next = 1'b1;
                byte_idx_next  = byte_idx + 2'd1;
                if (pop && (count_next == 2'd0)) begin
                    state_next    = IDLE;
                    byte_idx_next = 2'd0;
                end
            end
            default: begin
                state_next    = IDLE;
                byte_idx_next = 2'd0;
            end
        endcase
    end

    // FSM state, byte index and registered byte outputs.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
        end else begin
            state     <= state_next;
            byte_idx  <= byte_idx_next;
            data_out  <= data_out_next;
            valid_out <= valid_out_next;
        end
    end

    // Two-entry word FIFO: head is always the word being serialised, tail is the queued one.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            count     <= 2'd0;
            head_word <= 32'h0;
            tail_word <= 32'h0;
        end else begin
            count <= count_next;
            if (pop) begin
                if (push) begin
                    head_word <= data_in;
                end else begin
                    head_word <= tail_word;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head_word <= data_in;
                end else begin
                    tail_word <= data_in;
                end
            end
        end
    end

    // Sticky flag for any word offered while the FIFO was full.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            err_overflow <= 1'b0;
        end else if (drop) begin
            err_overflow <= 1'b1;
        end
    end

endmodule

// File: doc/word_to_byte_lane.md
WORD_TO_BYTE_LANE -- requirements
Module: word_to_byte_lane

Interface
REQ-001 The block SHALL have these ports:
- clk_4f, input, 1: sole clock; all state updates on its rising edge; runs at 4x the lane word rate.
- reset_L, input, 1: asynchronous, active-low reset.
- data_in, input, 32: lane word from the striping demux (lane_0 or lane_1).
- valid_in, input, 1: data_in carries a valid word this cycle.
- in_ready, output, 1: block can accept a word this cycle.
- data_out, output, 8: byte stream, most significant byte first.
- valid_out, output, 1: data_out carries a data byte (0 means idle symbol).
- err_overflow, output, 1: sticky flag for a dropped input word.

REQ-002 The block SHALL have one parameter: IDLE_SYM, default 8'hBC, the byte driven on data_out when no data is available.

Function
REQ-003 The block SHALL contain a 2-entry word FIFO with a 2-bit occupancy count (range 0..2).
- Push when valid_in && in_ready at a rising edge.
- Pop when the last byte of the head word is emitted.

REQ-004 in_ready SHALL be combinational and equal to (count < 2).
- When full, in_ready=0 even if a pop occurs in the same cycle.
- No push-through when full.

REQ-005 valid_in=1 while in_ready=0 SHALL drop the word and set err_overflow=1.
- err_overflow clears only on reset.
- FIFO contents and count are unchanged by a dropped word.

REQ-006 The control FSM SHALL have two states, IDLE and SEND.
- IDLE -> SEND at the edge where the FIFO is non-empty, or a push occurs into an empty FIFO.
- SEND -> IDLE at the edge emitting byte index 3 when no further word is available, i.e. count after the pop and push is 0.

REQ-007 In SEND, a 2-bit byte_idx SHALL increment each cycle, wrapping 3 -> 0.
- byte_idx is 0 on entry to SEND.
- Emitted byte: idx0=data[31:24], idx1=[23:16], idx2=[15:8], idx3=[7:0].

REQ-008 data_out and valid_out SHALL be registered.
- Latency: a word pushed at edge N into an empty FIFO while in IDLE drives byte idx0 after edge N+1.
- Its idx3 appears after edge N+4.

REQ-009 Back-to-back words SHALL stream without gap bytes.
- If a second word is present when idx3 is emitted, its idx0 follows on the next cycle with valid_out held at 1.

REQ-010 In IDLE, the registered outputs SHALL be data_out=IDLE_SYM and valid_out=0.

REQ-011 Push and pop in the same edge SHALL leave count unchanged and keep word order.
- Pop removes the head.
- The new word goes to the tail.

REQ-012 Sustained input at one word per 4 cycles SHALL never assert err_overflow.

Reset
REQ-013 While reset_L=0, regardless of clock:
- data_out=8'h00, valid_out=0, err_overflow=0.
- count=0, byte_idx=0, FSM=IDLE.
- in_ready=1 (combinational from count).

REQ-014 Reset asserted mid-word SHALL abort that word and discard all FIFO contents; no partial word is resumed.

REQ-015 After reset_L rises, the first rising edge SHALL drive data_out=IDLE_SYM if no word is pushed.

Verification
REQ-016 Reset then no input -> data_out=8'h00 during reset; after release data_out=8'hBC with valid_out=0 every cycle.

REQ-017 Single word 32'h11223344 pushed at edge N -> data_out=11,22,33,44 after edges N+1..N+4 with valid_out=1; then 8'hBC with valid_out=0.

REQ-018 Words AAAAAAAA then EEEEEEEE, each pushed 4 cycles apart -> 8 consecutive valid bytes AA,AA,AA,AA,EE,EE,EE,EE with no idle symbol between them; err_overflow=0.

REQ-019 valid_in held 1 for 4 consecutive cycles with words W0..W3 -> W0 and W1 accepted; in_ready=0 on cycle 3; W2 dropped and err_overflow=1. Output is W0 then W1 bytes, plus any word pushed later when in_ready=1.

REQ-020 Full FIFO with pop at the same edge as valid_in=1 -> word not accepted (in_ready=0) and err_overflow=1; count goes 2 -> 1.

REQ-021 reset_L pulsed low during byte idx1 of 32'hCCCCCCCC with a second word queued -> outputs reset immediately; after release only 8'hBC appears and the queued word is never emitted.
